// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl -- pipeline-side initiator for the HI/LO multiply/divide unit.
//
// Registers the E-stage operands and op code into a one-cycle start pulse,
// follows the unit's busy window with an IDLE/ISSUE/BUSY FSM and holds the
// D stage while a HI/LO-class instruction there could race that window.
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   e_op, e_kill        E-stage HI/LO class (1..6 issue) and cancel
//   e_rs, e_rt          forwarded operands
//   d_op                D-stage HI/LO class (1..8 can stall)
//   md_busy             busy from the multiply/divide unit
//   md_D1, md_D2, md_op registered operands / op code to the unit (op 0 idle)
//   md_start            registered one-cycle start pulse
//   stall               combinational D-stage hold
//   md_err              sticky protocol error (MD_TIMEOUT_CHK_EN only)
//
// Optional feature: define MD_TIMEOUT_CHK_EN to add the BUSY timeout and the
// md_err flag (also set by an E-stage issue ignored while not IDLE).

module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_op,
  input  logic        e_kill,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic [3:0]  d_op,
  input  logic        md_busy,
  output logic [31:0] md_D1,
  output logic [31:0] md_D2,
  output logic [3:0]  md_op,
  output logic        md_start,
`ifdef MD_TIMEOUT_CHK_EN
  output logic        md_err,
`endif
  output logic        stall
);

  // cnt saturates at 255, so a limit at or above that could never trip.
  if (MULT_CYCLES + 4 > 254 || DIV_CYCLES + 4 > 254) begin : g_bad_limit
    $error("md_issue_ctrl: busy limits must fit below the 8-bit counter ceiling");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

  state_t     r_state, w_next;
  logic [7:0] r_cnt;
  logic       r_seen_busy;
  logic       w_e_hilo, w_d_hilo, w_issue, w_busy_done, w_to_idle, w_timeout;

  assign w_e_hilo    = (e_op >= 4'd1) && (e_op <= 4'd6);
  assign w_d_hilo    = (d_op >= 4'd1) && (d_op <= 4'd8);
  assign w_issue     = (r_state == S_IDLE) && !e_kill && w_e_hilo;
  // seen_busy is the previous cycle's sample, so a low md_busy here is a real fall.
  assign w_busy_done = !md_busy && r_seen_busy;

`ifdef MD_TIMEOUT_CHK_EN
  logic [7:0] w_limit;
  logic       r_err;
  assign w_limit   = (md_op == 4'd1 || md_op == 4'd2) ? 8'(MULT_CYCLES + 4)
                                                      : 8'(DIV_CYCLES + 4);
  assign w_timeout = (r_cnt > w_limit);
  assign md_err    = r_err;
`else
  assign w_timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_ISSUE;
      // mthi/mtlo finish in the issue cycle; mult/div wait for the unit.
      S_ISSUE: w_next = (md_op >= 4'd1 && md_op <= 4'd4) ? S_BUSY : S_IDLE;
      S_BUSY:  if (w_busy_done || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    stall     = reset && w_d_hilo && ((r_state != S_IDLE) || w_issue);
    w_to_idle = (r_state != S_IDLE) && (w_next == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_D1       <= '0;
      md_D2       <= '0;
      md_op       <= '0;
      md_start    <= 1'b0;
      r_cnt       <= '0;
      r_seen_busy <= 1'b0;
    end else begin
      md_start <= w_issue;
      if (w_issue) begin
        md_D1 <= e_rs;
        md_D2 <= e_rt;
        md_op <= e_op;
      end else if (w_to_idle) begin
        md_op <= '0;
      end
      case (r_state)
        S_ISSUE: begin
          r_cnt       <= '0;
          r_seen_busy <= 1'b0;
        end
        S_BUSY: begin
          if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          if (md_busy)        r_seen_busy <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MD_TIMEOUT_CHK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_err <= 1'b0;
    else if (((r_state == S_BUSY) && w_timeout) ||
             ((r_state != S_IDLE) && !e_kill && w_e_hilo))
      r_err <= 1'b1;
  end
`endif

endmodule
